mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL expose parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu.
REQ-002 The block SHALL expose parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu.
REQ-003 Port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port reset  input  1  reset; synchronous and active-high.
REQ-005 Port start  input  1  request to launch the operation encoded on op.
REQ-006 Port op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-007 Port D1  input  32  rs operand, driven from register-file read port 1.
REQ-008 Port D2  input  32  rt operand, driven from register-file read port 2.
REQ-009 Port busy  output  1  high while a multi-cycle operation is in progress.
REQ-010 Port HI  output  32  current HI register (mfhi source).
REQ-011 Port LO  output  32  current LO register (mflo source).

Function
REQ-012 The block SHALL have two states: IDLE and BUSY.
REQ-013 In IDLE, start=1 with op 1-4 at an edge SHALL latch D1, D2 and op, load a down-counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-014 In IDLE, start=1 with op 5 (mthi) or 6 (mtlo) SHALL write D1 into HI or LO at that edge, with no busy cycle.
REQ-015 busy SHALL be a registered output: 1 exactly while in BUSY, i.e. for N consecutive cycles after the launching edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 In BUSY the counter SHALL decrement each edge; at the edge where it reaches zero, HI/LO SHALL update and the state SHALL return to IDLE, so busy falls and new HI/LO are visible in the same cycle.
REQ-017 start with any op while busy=1 SHALL be ignored; operands and HI/LO stay unchanged.
REQ-018 start with op 0 or 7 SHALL have no effect.
REQ-019 mult SHALL form the signed 64-bit product; multu the unsigned product; HI=bits[63:32], LO=bits[31:0].
REQ-020 div SHALL be signed and truncate toward zero: LO=quotient, HI=remainder carrying the dividend's sign.
REQ-021 divu SHALL be unsigned: LO=quotient, HI=remainder.
REQ-022 Divisor 0 SHALL still occupy DIV_CYCLES busy cycles and SHALL leave HI and LO unchanged.
REQ-023 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-024 Results SHALL depend only on operands latched at the launching edge; later changes on D1/D2 SHALL have no effect.
REQ-025 HI and LO SHALL be readable combinationally at all times; during BUSY they SHALL hold their pre-launch values.

Reset
REQ-026 When reset=1 at an edge, HI=0, LO=0, busy=0, counter=0 and state=IDLE, with priority over start.
REQ-027 A reset during BUSY SHALL abort the operation and discard its result.

Configuration
REQ-028 Macro MDU_DIV_EN defined: div/divu SHALL behave as specified above.
REQ-029 Macro MDU_DIV_EN undefined: no divider logic SHALL be built; op 3/4 SHALL be treated as no-ops, with busy staying 0 and HI/LO unchanged.

Verification
REQ-030 The bench SHALL check: mult, D1=0xFFFFFFFE (-2), D2=3 -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 The bench SHALL check: multu, D1=0xFFFFFFFF, D2=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 The bench SHALL check: div, D1=0xFFFFFFF9 (-7), D2=2 -> busy=1 for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Without MDU_DIV_EN, busy stays 0 and HI/LO are unchanged.
REQ-033 The bench SHALL check: divu by 0 after mthi 0x12345678 -> busy=1 for 10 cycles; HI stays 0x12345678 and LO is unchanged.
REQ-034 The bench SHALL check: start mult in cycle 2 of a running div -> ignored; only the div result appears, at the 10th cycle.
REQ-035 The bench SHALL check: reset asserted in cycle 3 of a mult -> next cycle busy=0, HI=0, LO=0; the aborted result never appears.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO register pair fed by mult/multu/div/divu/mthi/mtlo.
// Latency: MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) busy cycles; mthi/mtlo take effect at the launching edge.
// Backpressure: none; a start that arrives while busy is high is dropped, not queued.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   reset      synchronous, active-high; clears HI/LO/busy and aborts any operation
//   start, op  launch request and its opcode (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none)
//   D1, D2     rs / rt operands
//   busy       registered, high exactly while an operation is in flight
//   HI, LO     result registers, always readable
//
// Build option: define MDU_DIV_EN to build the divider; without it div/divu are no-ops.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic          state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          res_wr;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

`ifdef MDU_DIV_EN
  logic          div_sgn;
  logic [31:0]   ua;
  logic [31:0]   ub;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   div_q;
  logic [31:0]   div_r;

  // Signed divide done on magnitudes, then signs reapplied: quotient gets
  // sign(a)^sign(b), remainder follows the dividend. 0x80000000 / -1 falls
  // out naturally as 0x80000000 rem 0 since the magnitude wraps to itself.
  always_comb begin
    div_sgn = (op_q == OP_DIV);
    ua      = (div_sgn && a_q[31]) ? -a_q : a_q;
    ub      = (div_sgn && b_q[31]) ? -b_q : b_q;
    uq      = (ub == 32'd0) ? 32'd0 : ua / ub;
    ur      = (ub == 32'd0) ? 32'd0 : ua % ub;
    div_q   = (div_sgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
    div_r   = (div_sgn && a_q[31]) ? -ur : ur;
  end
`endif

  // Result of the latched operation, consumed only on the final busy edge.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    res_wr = 1'b0;
    res_hi = HI;
    res_lo = LO;
    case (op_q)
      OP_MULT: begin
        res_wr = 1'b1;
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_wr = 1'b1;
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        // Divide by zero burns the cycles but leaves HI/LO alone.
        if (b_q != 32'd0) begin
          res_wr = 1'b1;
          res_hi = div_r;
          res_lo = div_q;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else if (state == IDLE) begin
      if (start) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            state <= BUSY;
            cnt   <= CW'(MULT_CYCLES);
            op_q  <= op;
            a_q   <= D1;
            b_q   <= D2;
          end
`ifdef MDU_DIV_EN
          OP_DIV, OP_DIVU: begin
            state <= BUSY;
            cnt   <= CW'(DIV_CYCLES);
            op_q  <= op;
            a_q   <= D1;
            b_q   <= D2;
          end
`endif
          OP_MTHI: HI <= D1;
          OP_MTLO: LO <= D1;
          default: ;
        endcase
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= IDLE;
        if (res_wr) begin
          HI <= res_hi;
          LO <= res_lo;
        end
      end
    end
  end

  // state is itself a flop, so busy is a registered output.
  assign busy = state;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  typedef longint unsigned u64_t;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .D1    (D1),
    .D2    (D2),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int cycles_for(input logic [2:0] o);
    case (o)
      3'd1, 3'd2: return 5;
      3'd3, 3'd4: return DIV_EN ? 10 : 0;
      default:    return 0;
    endcase
  endfunction

  // Architectural effect of one accepted operation on HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    u64_t   pu;
    int     sa;
    int     sb;
    case (o)
      3'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      3'd2: begin
        pu = u64_t'(a) * u64_t'(b);
        exp_hi = pu[63:32];
        exp_lo = pu[31:0];
      end
      3'd3: if (DIV_EN && b != 32'd0) begin
        sa = $signed(a);
        sb = $signed(b);
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          exp_lo = 32'h80000000;
          exp_hi = 32'h0;
        end else begin
          exp_lo = sa / sb;
          exp_hi = sa % sb;
        end
      end
      3'd4: if (DIV_EN && b != 32'd0) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
      3'd5: exp_hi = a;
      3'd6: exp_lo = a;
      default: ;
    endcase
  endtask

  // Launch one op, watch busy and held HI/LO every cycle, scramble inputs
  // during busy, optionally fire a mult at busy cycle 2, then check result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int n = cycles_for(o);
    logic [31:0] ph = exp_hi;
    logic [31:0] pl = exp_lo;
    @(negedge clk);
    start = 1'b1; op = o; D1 = a; D2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); D1 = $urandom; D2 = $urandom;
    for (int k = 1; k <= n; k++) begin
      chk({tag, "/busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "/hold_hi"}, HI, ph);
      chk({tag, "/hold_lo"}, LO, pl);
      if (inject && k == 2 && n >= 3) begin
        start = 1'b1; op = 3'd1; D1 = $urandom; D2 = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    model(o, a, b);
    chk({tag, "/idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "/hi"}, HI, exp_hi);
    chk({tag, "/lo"}, LO, exp_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] lo_before;

    reset = 1'b1; start = 1'b1; op = 3'd5; D1 = 32'hDEADBEEF; D2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset = 1'b0; start = 1'b0; op = 3'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;

    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_hi_const", HI, 32'hFFFFFFFF);
    chk("mult_lo_const", LO, 32'hFFFFFFFA);

    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_hi_const", HI, 32'hFFFFFFFE);
    chk("multu_lo_const", LO, 32'h00000001);

    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo_const", LO, DIV_EN ? 32'hFFFFFFFD : 32'h00000001);
    chk("div_hi_const", HI, DIV_EN ? 32'hFFFFFFFF : 32'hFFFFFFFE);

    run_op("mthi", 3'd5, 32'h12345678, 32'd0, 1'b0);
    chk("mthi_const", HI, 32'h12345678);
    lo_before = exp_lo;
    run_op("divu0", 3'd4, 32'hCAFEF00D, 32'd0, 1'b0);
    chk("divu0_hi_const", HI, 32'h12345678);
    chk("divu0_lo_const", LO, lo_before);

    run_op("mtlo", 3'd6, 32'h0BADF00D, 32'd0, 1'b0);
    run_op("div_inj", 3'd3, 32'd1000, 32'hFFFFFFF9, 1'b1);
    run_op("mult_inj", 3'd1, 32'h00010001, 32'h7FFFFFFF, 1'b1);

    run_op("div_min", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    if (DIV_EN) begin
      chk("div_min_lo_const", LO, 32'h80000000);
      chk("div_min_hi_const", HI, 32'h00000000);
    end

    run_op("nop0", 3'd0, 32'h11111111, 32'h2, 1'b0);
    run_op("nop7", 3'd7, 32'h22222222, 32'h3, 1'b0);

    // Reset on busy cycle 3 of a mult: aborted result must never land.
    run_op("pre_hi", 3'd5, 32'hA5A5A5A5, 32'd0, 1'b0);
    run_op("pre_lo", 3'd6, 32'h5A5A5A5A, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd1; D1 = 32'd7; D2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_c3", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_quiet_busy", {31'd0, busy}, 32'd0);
      chk("abort_quiet_hi", HI, 32'd0);
      chk("abort_quiet_lo", LO, 32'd0);
    end

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      run_op("rand", ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
